eeg_oram_acc: RTL and testbench
===============================

EEG_ORAM_ACC -- requirements
Module: eeg_oram_acc

Interface
REQ-001 SHALL have parameter BANK_NUM, default 16, meaning number of independent output-RAM banks (flattened ORAM x OMUX).
REQ-002 SHALL have parameter ADD_AW, default 8, meaning per-bank address width; depth = 2^ADD_AW words.
REQ-003 SHALL have parameter DAT_DW, default 8, meaning signed data width.
REQ-004 SHALL have ports in the order listed; clk is the single clock, and rst_n is an asynchronous, active-low reset.
REQ-005 clk  in  1  clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 DIN_VLD / DIN_RDY  in / out  BANK_NUM  per-bank write handshake.
REQ-008 DIN_ACC  in  BANK_NUM  write mode: 1 = accumulate into the stored word, 0 = overwrite.
REQ-009 DIN_ADD / DIN_DAT  in  BANK_NUM*ADD_AW / BANK_NUM*DAT_DW  write address and data.
REQ-010 ADD_VLD / ADD_RDY  in / out  BANK_NUM  per-bank read-request handshake.
REQ-011 ADD_LST  in  BANK_NUM  last-of-burst tag, forwarded to DAT_LST.
REQ-012 ADD_CLR  in  BANK_NUM  clear-on-read: zero the word after reading it.
REQ-013 ADD_ADD  in  BANK_NUM*ADD_AW  read address.
REQ-014 DAT_VLD / DAT_RDY  out / in  BANK_NUM  per-bank read-data handshake.
REQ-015 DAT_LST  out  BANK_NUM  last tag aligned with DAT_DAT.
REQ-016 DAT_DAT  out  BANK_NUM*DAT_DW  read data.

Function
REQ-017 Each bank SHALL be fully independent and SHALL use one 1R1W synchronous RAM macro wrapper (read data valid the cycle after rena).
REQ-018 A transfer SHALL occur only on VLD&RDY high at a rising clk edge; VLD/payload held by source until accepted.
REQ-019 Per-bank FSM states: IDLE, ACC_WB, CLR_WB; reset state IDLE.
REQ-020 In IDLE, DIN_RDY SHALL be 1; in ACC_WB and CLR_WB, DIN_RDY SHALL be 0.
REQ-021 Overwrite (DIN_ACC=0) accepted at edge T SHALL write the RAM at T; FSM SHALL stay IDLE.
REQ-022 Accumulate accepted at T SHALL issue a RAM read of DIN_ADD at T and go to ACC_WB; in ACC_WB it SHALL write sat(old+DIN_DAT) to the captured address, then return to IDLE; write-to-readable latency is 2 cycles.
REQ-023 Sum SHALL be computed at DAT_DW+1 bits and saturated to [-2^(DAT_DW-1), 2^(DAT_DW-1)-1].
REQ-024 Back-to-back accumulates to the same address SHALL be correct: each sees the prior sum, with no bypass needed given the 1-cycle DIN_RDY bubble.
REQ-025 ADD_RDY SHALL equal (state==IDLE) & ~DIN_VLD & credit_ok; a pending write always wins.
REQ-026 The output buffer SHALL be a 2-entry FIFO per bank; credit_ok SHALL be 1 when (FIFO occupancy + in-flight reads) < 2.
REQ-027 A read accepted at T SHALL place {data, ADD_LST} into the FIFO at T+1; DAT_VLD SHALL be high from T+2 (latency 2).
REQ-028 A read with ADD_CLR=1 SHALL enter CLR_WB and write 0 to the same address at T+1, then return to IDLE.
REQ-029 DAT_VLD SHALL be FIFO non-empty and DAT_DAT/DAT_LST SHALL be the FIFO head; both SHALL be stable while DAT_VLD & ~DAT_RDY.
REQ-030 A simultaneous FIFO push and pop SHALL keep occupancy unchanged; FIFO pointers SHALL wrap modulo 2.
REQ-031 DAT_RDY SHALL NOT combinationally affect ADD_RDY or DIN_RDY.

Reset
REQ-032 With rst_n low: FSMs SHALL be IDLE; DAT_VLD, DAT_LST and DAT_DAT SHALL be 0; FIFO and in-flight counters SHALL be 0; DIN_RDY SHALL be 1. RAM contents are not reset.
REQ-033 Assertion mid-operation SHALL abort any ACC_WB/CLR_WB write-back and discard in-flight reads immediately.

Verification
REQ-034 Overwrite bank 0 addr 5 = 0x12, then read addr 5 with LST=1 -> DAT_DAT=0x12, DAT_LST=1, DAT_VLD rises 2 cycles after the read is accepted.
REQ-035 Write 0x70, then accumulate 0x20 at the same address -> read returns 0x7F (saturated); write 0x90 (-112), accumulate 0xE0 (-32) -> read returns 0x80.
REQ-036 Three consecutive accumulates of 1 to addr 0 (initially 0) -> DIN_RDY toggles 1,0 per op; final read = 3.
REQ-037 DAT_RDY=0 with ADD_VLD held -> exactly 2 reads accepted, then ADD_RDY=0; release DAT_RDY -> data pops in order, none lost or duplicated.
REQ-038 Read addr 9 (=0x33) with CLR=1 -> returns 0x33; a DIN_VLD asserted in the next cycle stalls 1 cycle; a re-read of addr 9 returns 0.
REQ-039 DIN_VLD and ADD_VLD asserted in the same cycle -> write accepted, ADD_RDY=0; reset pulsed during ACC_WB -> all outputs 0 and DIN_RDY=1 on the next edge.

Source files
------------

// File: rtl/eeg_oram_acc.sv
// Banked output RAM with per-bank overwrite/accumulate write port and a
// read port that supports clear-on-read, buffered by a 2-entry output FIFO.

module eeg_oram_acc_ram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          wena,
  input  logic [AW-1:0] wadd,
  input  logic [DW-1:0] wdat,
  input  logic          rena,
  input  logic [AW-1:0] radd,
  output logic [DW-1:0] rdat
);

  logic [DW-1:0] mem [2**AW];

  // NOTE: RAM arrays carry no reset; their contents are defined only by writes.
  always_ff @(posedge clk) begin
    if (wena) mem[wadd] <= wdat;
    if (rena) rdat <= mem[radd];
  end

endmodule

module eeg_oram_acc #(
  parameter int BANK_NUM = 16,
  parameter int ADD_AW   = 8,
  parameter int DAT_DW   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [BANK_NUM-1:0]        DIN_VLD,
  output logic [BANK_NUM-1:0]        DIN_RDY,
  input  logic [BANK_NUM-1:0]        DIN_ACC,
  input  logic [BANK_NUM*ADD_AW-1:0] DIN_ADD,
  input  logic [BANK_NUM*DAT_DW-1:0] DIN_DAT,
  input  logic [BANK_NUM-1:0]        ADD_VLD,
  output logic [BANK_NUM-1:0]        ADD_RDY,
  input  logic [BANK_NUM-1:0]        ADD_LST,
  input  logic [BANK_NUM-1:0]        ADD_CLR,
  input  logic [BANK_NUM*ADD_AW-1:0] ADD_ADD,
  output logic [BANK_NUM-1:0]        DAT_VLD,
  input  logic [BANK_NUM-1:0]        DAT_RDY,
  output logic [BANK_NUM-1:0]        DAT_LST,
  output logic [BANK_NUM*DAT_DW-1:0] DAT_DAT
);

  typedef enum logic [1:0] {IDLE, ACC_WB, CLR_WB} state_t;

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    state_t              state, state_nxt;
    logic [ADD_AW-1:0]   din_add, add_add, wb_add, wadd, radd;
    logic [DAT_DW-1:0]   din_dat, wb_dat, wdat, rdat, sat_dat;
    logic [DAT_DW:0]     sum;
    logic                din_fire, add_fire, wena, rena, credit_ok;
    logic                rd_pend, rd_lst, push, pop, wr_ptr, rd_ptr;
    logic [1:0]          cnt;
    logic [DAT_DW-1:0]   fifo_dat [2];
    logic [1:0]          fifo_lst;

    assign din_add = DIN_ADD[b*ADD_AW +: ADD_AW];
    assign din_dat = DIN_DAT[b*DAT_DW +: DAT_DW];
    assign add_add = ADD_ADD[b*ADD_AW +: ADD_AW];

    // Credits count both buffered words and the read still inside the RAM,
    // so an accepted read always has a FIFO slot waiting for it.
    assign credit_ok  = (cnt + {1'b0, rd_pend}) < 2'd2;
    assign DIN_RDY[b] = (state == IDLE);
    assign ADD_RDY[b] = (state == IDLE) & ~DIN_VLD[b] & credit_ok;
    assign din_fire   = DIN_VLD[b] & DIN_RDY[b];
    assign add_fire   = ADD_VLD[b] & ADD_RDY[b];

    assign sum = {rdat[DAT_DW-1], rdat} + {wb_dat[DAT_DW-1], wb_dat};

    always_comb begin
      sat_dat = sum[DAT_DW-1:0];
      if (sum[DAT_DW] != sum[DAT_DW-1])
        sat_dat = {sum[DAT_DW], {(DAT_DW-1){~sum[DAT_DW]}}};
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
      state_nxt = state;
      wena      = 1'b0;
      wadd      = din_add;
      wdat      = din_dat;
      rena      = 1'b0;
      radd      = din_add;
      case (state)
        IDLE: begin
          if (din_fire) begin
            if (DIN_ACC[b]) begin
              rena      = 1'b1;
              state_nxt = ACC_WB;
            end else begin
              wena = 1'b1;
            end
          end else if (add_fire) begin
            rena = 1'b1;
            radd = add_add;
            if (ADD_CLR[b]) state_nxt = CLR_WB;
          end
        end
        ACC_WB: begin
          wena      = 1'b1;
          wadd      = wb_add;
          wdat      = sat_dat;
          state_nxt = IDLE;
        end
        CLR_WB: begin
          wena      = 1'b1;
          wadd      = wb_add;
          wdat      = '0;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
    end

    assign push = rd_pend;
    assign pop  = (cnt != 2'd0) & DAT_RDY[b];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_pend <= 1'b0;
        cnt     <= 2'd0;
        wr_ptr  <= 1'b0;
        rd_ptr  <= 1'b0;
      end else begin
        rd_pend <= add_fire;
        cnt     <= cnt + {1'b0, push} - {1'b0, pop};
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
      end
    end

    // Payload registers are qualified by the control path and need no reset.
    always_ff @(posedge clk) begin
      if (din_fire) begin
        wb_add <= din_add;
        wb_dat <= din_dat;
      end else if (add_fire) begin
        wb_add <= add_add;
      end
      if (add_fire) rd_lst <= ADD_LST[b];
      if (push) begin
        fifo_dat[wr_ptr] <= rdat;
        fifo_lst[wr_ptr] <= rd_lst;
      end
    end

    assign DAT_VLD[b]                  = (cnt != 2'd0);
    assign DAT_DAT[b*DAT_DW +: DAT_DW] = DAT_VLD[b] ? fifo_dat[rd_ptr] : '0;
    assign DAT_LST[b]                  = DAT_VLD[b] & fifo_lst[rd_ptr];

    eeg_oram_acc_ram #(.AW(ADD_AW), .DW(DAT_DW)) u_ram (
      .clk  (clk),
      .wena (wena),
      .wadd (wadd),
      .wdat (wdat),
      .rena (rena),
      .radd (radd),
      .rdat (rdat)
    );
  end

endmodule

// File: tb/tb_eeg_oram_acc.sv
// Self-checking bench for eeg_oram_acc: transaction-level model of every bank
// (atomic RAM updates plus an ordered output queue) compared every cycle.

module tb_eeg_oram_acc;

  localparam int NB = 16;
  localparam int AW = 8;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NB-1:0]    din_vld = '0, din_acc = '0, add_vld = '0, add_lst = '0;
  logic [NB-1:0]    add_clr = '0, dat_rdy = '1;
  logic [NB*AW-1:0] din_add = '0, add_add = '0;
  logic [NB*DW-1:0] din_dat = '0;
  logic [NB-1:0]    DIN_RDY, ADD_RDY, DAT_VLD, DAT_LST;
  logic [NB*DW-1:0] DAT_DAT;

  int n_checks = 0;
  int n_fail   = 0;

  eeg_oram_acc #(.BANK_NUM(NB), .ADD_AW(AW), .DAT_DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .DIN_VLD(din_vld), .DIN_RDY(DIN_RDY), .DIN_ACC(din_acc),
    .DIN_ADD(din_add), .DIN_DAT(din_dat),
    .ADD_VLD(add_vld), .ADD_RDY(ADD_RDY), .ADD_LST(add_lst),
    .ADD_CLR(add_clr), .ADD_ADD(add_add),
    .DAT_VLD(DAT_VLD), .DAT_RDY(dat_rdy), .DAT_LST(DAT_LST), .DAT_DAT(DAT_DAT)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit         m_busy [NB];
  bit         m_pend [NB];
  bit         m_pend_lst [NB];
  logic [7:0] m_pend_dat [NB];
  logic [7:0] m_mem [NB][256];
  int         m_qn [NB];
  logic [7:0] m_qd [NB][2];
  bit         m_ql [NB][2];
  bit         m_din_fire [NB];
  bit         m_add_fire [NB];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t: handshake wait budget exhausted", name, $time);
  endtask

  function automatic logic [7:0] sat8(input logic [7:0] a, input logic [7:0] b);
    int sa, sb, s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = sa + sb;
    if (s > 127)  return 8'h7F;
    if (s < -128) return 8'h80;
    return s[7:0];
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_busy[b] = 0; m_pend[b] = 0; m_qn[b] = 0;
      m_din_fire[b] = 0; m_add_fire[b] = 0;
    end
  endtask

  task automatic model_step();
    for (int b = 0; b < NB; b++) begin
      bit din_ok, add_ok, pop;
      logic [7:0] a;
      din_ok = din_vld[b] && !m_busy[b];
      add_ok = add_vld[b] && !m_busy[b] && !din_vld[b] && (m_qn[b] + int'(m_pend[b])) < 2;
      pop    = (m_qn[b] > 0) && dat_rdy[b];
      if (pop) begin
        m_qd[b][0] = m_qd[b][1];
        m_ql[b][0] = m_ql[b][1];
        m_qn[b]--;
      end
      if (m_pend[b]) begin
        m_qd[b][m_qn[b]] = m_pend_dat[b];
        m_ql[b][m_qn[b]] = m_pend_lst[b];
        m_qn[b]++;
      end
      m_pend[b] = 0;
      m_busy[b] = 0;
      if (din_ok) begin
        a = din_add[b*AW +: AW];
        if (din_acc[b]) begin
          m_mem[b][a] = sat8(m_mem[b][a], din_dat[b*DW +: DW]);
          m_busy[b]   = 1;
        end else begin
          m_mem[b][a] = din_dat[b*DW +: DW];
        end
      end else if (add_ok) begin
        a             = add_add[b*AW +: AW];
        m_pend[b]     = 1;
        m_pend_dat[b] = m_mem[b][a];
        m_pend_lst[b] = add_lst[b];
        if (add_clr[b]) begin
          m_mem[b][a] = 8'h00;
          m_busy[b]   = 1;
        end
      end
      m_din_fire[b] = din_ok;
      m_add_fire[b] = add_ok;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else        model_step();
  end

  task automatic compare();
    logic [NB-1:0]    e_din, e_add, e_vld, e_lst;
    logic [NB*DW-1:0] e_dat, mask;
    for (int b = 0; b < NB; b++) begin
      e_din[b] = !m_busy[b];
      e_add[b] = !m_busy[b] && !din_vld[b] && (m_qn[b] + int'(m_pend[b])) < 2;
      e_vld[b] = (m_qn[b] != 0);
      e_lst[b] = e_vld[b] & m_ql[b][0];
      e_dat[b*DW +: DW] = e_vld[b] ? m_qd[b][0] : 8'h00;
      mask[b*DW +: DW]  = {DW{e_vld[b]}};
    end
    check("model_din_rdy", DIN_RDY, e_din);
    check("model_add_rdy", ADD_RDY, e_add);
    check("model_dat_vld", DAT_VLD, e_vld);
    check("model_dat_lst", DAT_LST & e_vld, e_lst);
    check("model_dat_dat", DAT_DAT & mask, e_dat);
  endtask

  initial forever begin
    @(negedge clk);
    compare();
  end

  // Bank-0 directed helpers; each starts and ends 1 time unit after a rising edge.
  task automatic wr(input bit acc, input int a, input logic [7:0] d, output int waits);
    bit rdy;
    din_vld[0] = 1'b1; din_acc[0] = acc;
    din_add[AW-1:0] = a[AW-1:0]; din_dat[DW-1:0] = d;
    waits = 0; rdy = 0;
    while (!rdy && waits <= 20) begin
      @(negedge clk); rdy = DIN_RDY[0];
      @(posedge clk); if (!rdy) waits++;
    end
    if (!rdy) timeout("wr_handshake");
    #1 din_vld[0] = 1'b0;
  endtask

  task automatic rd(input int a, input bit lst, input bit clr);
    bit rdy;
    int waits;
    add_vld[0] = 1'b1; add_add[AW-1:0] = a[AW-1:0];
    add_lst[0] = lst; add_clr[0] = clr;
    waits = 0; rdy = 0;
    while (!rdy && waits <= 20) begin
      @(negedge clk); rdy = ADD_RDY[0];
      @(posedge clk); if (!rdy) waits++;
    end
    if (!rdy) timeout("rd_handshake");
    #1 add_vld[0] = 1'b0;
  endtask

  task automatic get(input logic [7:0] d, input bit l, input string name);
    int n;
    dat_rdy[0] = 1'b1;
    n = 0;
    while (!DAT_VLD[0] && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!DAT_VLD[0]) timeout(name);
    else check(name, {DAT_LST[0], DAT_DAT[DW-1:0]}, {l, d});
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, issued, got;
    bit ar, dv;
    logic [7:0] dd;

    repeat (2) @(posedge clk);
    #1;
    check("rst_din_rdy", DIN_RDY, {NB{1'b1}});
    check("rst_dat_vld", DAT_VLD, '0);
    check("rst_dat_lst", DAT_LST, '0);
    check("rst_dat_dat", DAT_DAT, '0);
    rst_n = 1'b1;

    // Known contents everywhere: overwrite every address of every bank with 0.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < NB; b++) begin
        din_vld[b] = 1'b1; din_acc[b] = 1'b0;
        din_add[b*AW +: AW] = 8'(a); din_dat[b*DW +: DW] = 8'h00;
      end
      @(posedge clk); #1;
    end
    din_vld = '0;

    // Overwrite then read with last tag, latency 2.
    wr(0, 5, 8'h12, w);
    rd(5, 1, 0);
    check("lat_not_yet", DAT_VLD[0], 1'b0);
    @(posedge clk); #1;
    check("lat_vld", DAT_VLD[0], 1'b1);
    check("lat_data", {DAT_LST[0], DAT_DAT[DW-1:0]}, {1'b1, 8'h12});
    @(posedge clk); #1;
    check("lat_popped", DAT_VLD[0], 1'b0);

    // Saturation both directions.
    wr(0, 7, 8'h70, w); wr(1, 7, 8'h20, w); rd(7, 0, 0); get(8'h7F, 0, "sat_pos");
    wr(0, 8, 8'h90, w); wr(1, 8, 8'hE0, w); rd(8, 0, 0); get(8'h80, 0, "sat_neg");

    // Back-to-back accumulates to one address.
    for (int i = 0; i < 3; i++) begin
      wr(1, 0, 8'h01, w);
      check("acc_rdy_low", DIN_RDY[0], 1'b0);
      if (i > 0) check("acc_bubble", w, 1);
    end
    rd(0, 0, 0); get(8'h03, 0, "acc_three");

    // Back-pressure: only two reads outstanding, then ordered drain.
    for (int i = 0; i < 4; i++) wr(0, 20 + i, 8'hA0 + 8'(i), w);
    issued = 0; got = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      add_vld[0] = (issued < 4);
      add_add[AW-1:0] = 8'(20 + issued);
      add_lst[0] = (issued == 3); add_clr[0] = 1'b0;
      dat_rdy[0] = (cyc >= 8);
      @(negedge clk);
      ar = ADD_RDY[0]; dv = DAT_VLD[0]; dd = DAT_DAT[DW-1:0];
      if (cyc == 7) begin
        check("bp_accepted", issued, 2);
        check("bp_add_rdy", ar, 1'b0);
      end
      @(posedge clk);
      if (add_vld[0] && ar) issued++;
      if (dv && dat_rdy[0]) begin
        check("bp_order", dd, 8'hA0 + 8'(got));
        got++;
      end
      #1;
    end
    add_vld[0] = 1'b0;
    check("bp_count", got, 4);
    check("bp_empty", DAT_VLD[0], 1'b0);

    // Clear-on-read.
    wr(0, 9, 8'h33, w);
    dat_rdy[0] = 1'b0;
    rd(9, 0, 1);
    wr(0, 10, 8'h44, w);
    check("clr_stall", w, 1);
    get(8'h33, 0, "clr_first");
    rd(9, 0, 0); get(8'h00, 0, "clr_second");

    // Simultaneous write and read request: write wins.
    din_vld[0] = 1'b1; din_acc[0] = 1'b0; din_add[AW-1:0] = 8'd30; din_dat[DW-1:0] = 8'h5A;
    add_vld[0] = 1'b1; add_add[AW-1:0] = 8'd30; add_lst[0] = 1'b1; add_clr[0] = 1'b0;
    @(negedge clk);
    check("both_add_rdy", ADD_RDY[0], 1'b0);
    check("both_din_rdy", DIN_RDY[0], 1'b1);
    @(posedge clk); #1 din_vld[0] = 1'b0;
    rd(30, 1, 0); get(8'h5A, 1, "both_read");

    // Randomized traffic on all banks, small address range for collisions.
    for (int cyc = 0; cyc < 2500; cyc++) begin
      for (int b = 0; b < NB; b++) begin
        if (!din_vld[b] || m_din_fire[b]) begin
          din_vld[b] = ($urandom_range(0, 2) == 0);
          din_acc[b] = 1'($urandom_range(0, 1));
          din_add[b*AW +: AW] = 8'($urandom_range(0, 3));
          din_dat[b*DW +: DW] = 8'($urandom);
        end
        if (!add_vld[b] || m_add_fire[b]) begin
          add_vld[b] = ($urandom_range(0, 2) == 0);
          add_lst[b] = 1'($urandom_range(0, 1));
          add_clr[b] = ($urandom_range(0, 3) == 0);
          add_add[b*AW +: AW] = 8'($urandom_range(0, 3));
        end
        dat_rdy[b] = ($urandom_range(0, 9) < 7);
      end
      @(posedge clk); #1;
    end
    for (int cyc = 0; cyc < 30; cyc++) begin
      for (int b = 0; b < NB; b++) begin
        if (m_din_fire[b]) din_vld[b] = 1'b0;
        if (m_add_fire[b]) add_vld[b] = 1'b0;
        dat_rdy[b] = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("drain_vld", DAT_VLD, '0);
    check("drain_din_rdy", DIN_RDY, {NB{1'b1}});

    // Reset during accumulate write-back with data buffered.
    dat_rdy[0] = 1'b0;
    rd(41, 1, 0);
    wr(1, 40, 8'h01, w);
    check("pre_rst_din_rdy", DIN_RDY[0], 1'b0);
    check("pre_rst_vld", DAT_VLD[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_din_rdy", DIN_RDY, {NB{1'b1}});
    check("mid_rst_dat_vld", DAT_VLD, '0);
    check("mid_rst_dat_lst", DAT_LST, '0);
    check("mid_rst_dat_dat", DAT_DAT, '0);
    @(posedge clk); #1;
    check("edge_rst_din_rdy", DIN_RDY, {NB{1'b1}});
    check("edge_rst_dat_vld", DAT_VLD, '0);
    rst_n = 1'b1;
    dat_rdy[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_dat_vld", DAT_VLD, '0);
    check("post_rst_din_rdy", DIN_RDY, {NB{1'b1}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
